// File: rtl/bip_loader_pkg.sv
// BIP program loader shared definitions.
// FSM encoding and protocol constants for loader and report serializer.
package bip_loader_pkg;

  localparam logic [7:0] START_BYTE_DEFAULT = 8'hA5;
  localparam logic [4:0] OPCODE_HALT        = 5'b00000;
  localparam int         N_REPORT_BYTES     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_LO = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RUN     = 3'd4,
    ST_TX_SEND = 3'd5,
    ST_TX_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/bip_report_serializer.sv
// Sends the little-endian {cycles, pc} halt report one byte at a time,
// waiting for the transmitter's done pulse between bytes.
module bip_report_serializer
  import bip_loader_pkg::*;
#(
  parameter int NB_BYTE  = 8,
  parameter int NB_PC    = 11,
  parameter int NB_CYCLE = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_PC-1:0]    i_pc,
  input  logic [NB_CYCLE-1:0] i_cycles,
  input  logic                i_tx_done,
  output logic                o_tx_start,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_done
);

  localparam int NB_IDX = $clog2(N_REPORT_BYTES);
  localparam int NB_REP = N_REPORT_BYTES * NB_BYTE;
  localparam int NB_PAD = 2 * NB_BYTE - NB_PC;
  localparam logic [NB_IDX-1:0] LAST_IDX =
    NB_IDX'(N_REPORT_BYTES - 1);

  logic [NB_REP-1:0]  r_report;
  logic [NB_IDX-1:0]  r_idx;
  logic               r_active;
  logic               r_tx_start;
  logic [NB_BYTE-1:0] r_tx_data;

  logic [NB_REP-1:0]  w_report;
  logic [NB_IDX-1:0]  w_idx_nxt;
  logic               w_wait;
  logic               w_last;

  assign w_report  = {i_cycles, {NB_PAD{1'b0}}, i_pc};
  assign w_idx_nxt = r_idx + NB_IDX'(1);
  // Byte is "in flight" once its start pulse has gone out.
  assign w_wait    = r_active & ~r_tx_start;
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_report   <= '0;
      r_idx      <= '0;
      r_active   <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_start <= 1'b0;
      if (i_start) begin
        r_active   <= 1'b1;
        r_idx      <= '0;
        r_report   <= w_report;
        r_tx_data  <= w_report[NB_BYTE-1:0];
        r_tx_start <= 1'b1;
      end else if (w_wait && i_tx_done) begin
        if (w_last) begin
          r_active <= 1'b0;
        end else begin
          r_idx      <= w_idx_nxt;
          r_tx_data  <= r_report[w_idx_nxt*NB_BYTE +: NB_BYTE];
          r_tx_start <= 1'b1;
        end
      end
    end
  end

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_done     = w_wait & i_tx_done & w_last;

endmodule

// File: rtl/bip_prog_loader.sv
// BIP boot loader: UART bytes -> instruction memory, run CPU to HALT,
// then report final PC and cycle count over UART.
module bip_prog_loader
  import bip_loader_pkg::*;
#(
  parameter int                NB_DATA            = 16,
  parameter int                NB_BYTE            = 8,
  parameter int                NB_OPCODE          = 5,
  parameter int                LOG2_N_INSMEM_ADDR = 11,
  parameter int                NB_CYCLE           = 16,
  parameter logic [NB_BYTE-1:0] START_BYTE        = START_BYTE_DEFAULT
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_BYTE-1:0]            i_rx_data,
  input  logic                          i_rx_done,
  input  logic                          i_tx_done,
  input  logic [LOG2_N_INSMEM_ADDR-1:0] i_cpu_addr_instr,
  input  logic [NB_DATA-1:0]            i_cpu_instruction,
  output logic                          o_imem_wr_en,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_imem_wr_addr,
  output logic [NB_DATA-1:0]            o_imem_wr_data,
  output logic                          o_cpu_reset,
  output logic                          o_cpu_valid,
  output logic                          o_tx_start,
  output logic [NB_BYTE-1:0]            o_tx_data,
  output logic                          o_busy,
  output logic                          o_load_err
);

  localparam int NB_ADDR = LOG2_N_INSMEM_ADDR;
  localparam logic [NB_ADDR-1:0]   LAST_ADDR = '1;
  localparam logic [NB_OPCODE-1:0] HALT_OP   =
    NB_OPCODE'(OPCODE_HALT);

  state_t              r_state;
  logic [NB_ADDR-1:0]  r_word_idx;
  logic [NB_BYTE-1:0]  r_lo;
  logic                r_wr_en;
  logic [NB_ADDR-1:0]  r_wr_addr;
  logic [NB_DATA-1:0]  r_wr_data;
  logic                r_cpu_reset;
  logic                r_cpu_valid;
  logic                r_busy;
  logic                r_load_err;
  logic [NB_CYCLE-1:0] r_cycles;

  logic                w_rx_start;
  logic                w_wr_halt;
  logic                w_run_halt;
  logic                w_ser_start;
  logic                w_ser_done;
  logic [NB_CYCLE-1:0] w_cycles_nxt;
  logic                w_unused;

  assign w_rx_start = i_rx_done & (i_rx_data == START_BYTE);
  assign w_wr_halt  =
    (r_wr_data[NB_DATA-1 -: NB_OPCODE] == HALT_OP);
  assign w_run_halt =
    (i_cpu_instruction[NB_DATA-1 -: NB_OPCODE] == HALT_OP);
  assign w_ser_start = (r_state == ST_RUN) & w_run_halt;
  // Saturate rather than wrap so long runs read as "at least max".
  assign w_cycles_nxt = (&r_cycles) ? r_cycles
                      : r_cycles + NB_CYCLE'(1);
  assign w_unused = ^i_cpu_instruction[NB_DATA-NB_OPCODE-1:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_word_idx  <= '0;
      r_lo        <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_reset <= 1'b1;
      r_cpu_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_load_err  <= 1'b0;
      r_cycles    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rx_start) begin
            r_word_idx <= '0;
            r_load_err <= 1'b0;
            r_cycles   <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_LOAD_LO;
          end
        end
        ST_LOAD_LO: begin
          if (i_rx_done) begin
            r_lo    <= i_rx_data;
            r_state <= ST_LOAD_HI;
          end
        end
        ST_LOAD_HI: begin
          if (i_rx_done) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_word_idx;
            r_wr_data <= {i_rx_data, r_lo};
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_wr_halt) begin
            r_cpu_reset <= 1'b0;
            r_cpu_valid <= 1'b1;
            r_state     <= ST_RUN;
          end else if (r_word_idx == LAST_ADDR) begin
            r_load_err <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_word_idx <= r_word_idx + NB_ADDR'(1);
            r_state    <= ST_LOAD_LO;
          end
        end
        ST_RUN: begin
          r_cycles <= w_cycles_nxt;
          if (w_run_halt) begin
            r_cpu_valid <= 1'b0;
            r_state     <= ST_TX_SEND;
          end
        end
        ST_TX_SEND: r_state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (w_ser_done) begin
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (i_tx_done) begin
            r_state <= ST_TX_SEND;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  bip_report_serializer #(
    .NB_BYTE  (NB_BYTE),
    .NB_PC    (NB_ADDR),
    .NB_CYCLE (NB_CYCLE)
  ) u_report (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (w_ser_start),
    .i_pc       (i_cpu_addr_instr),
    .i_cycles   (w_cycles_nxt),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_done     (w_ser_done)
  );

  assign o_imem_wr_en   = r_wr_en;
  assign o_imem_wr_addr = r_wr_addr;
  assign o_imem_wr_data = r_wr_data;
  assign o_cpu_reset    = r_cpu_reset;
  assign o_cpu_valid    = r_cpu_valid;
  assign o_busy         = r_busy;
  assign o_load_err     = r_load_err;

endmodule
